iter_block_multiplier: RTL and testbench
========================================

Name: iter_block_multiplier

Overview:
- Parametrised iterative schoolbook multiplier: unsigned DATA_LENGTH x DATA_LENGTH -> 2*DATA_LENGTH product.
- Operands are split into BLOCK_LENGTH blocks; one block-pair product is formed and accumulated per iteration through a fixed state sequence.
- Successor to the fixed 64/16 multiplier: width and block size are generic, it has a start/busy/done handshake, and block-pair skipping is optional.
- Sits as a shared arithmetic engine behind cipher/datapath controllers that tolerate multi-cycle latency.

Parameters:
- DATA_LENGTH, 64, operand width in bits; must be a multiple of BLOCK_LENGTH.
- BLOCK_LENGTH, 16, block width in bits; one hardware multiplier of BLOCK_LENGTH x BLOCK_LENGTH.
- LENGTH, 16, counter width in bits; must hold NUM_BLOCKS-1.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start_i  in  1  request; sampled only in idle.
- a_i  in  DATA_LENGTH  operand A; sampled in the start cycle.
- b_i  in  DATA_LENGTH  operand B; sampled in the start cycle.
- busy_o  out  1  high in every state except idle.
- done_o  out  1  one-cycle pulse in finish.
- result_o  out  2*DATA_LENGTH  product; registered and held until the next finish.

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-high.
- Reset: state=idle; busy_o=0, done_o=0, result_o=0; counters i,j=0; accumulator=0.
- Reset mid-operation: same reset values on the next edge; the partial result is discarded.
- States: idle, init, compute_mul, compute_acc, compute_chk, finish.
- idle: start_i=1 -> init. Latch a_i/b_i into operand registers. start_i is ignored in all other states (no queuing).
- init: clear accumulator; i=0, j=0 -> compute_mul.
- compute_mul: prod_reg <= a_blk[i]*b_blk[j] (2*BLOCK_LENGTH bits, unsigned) -> compute_acc.
- compute_acc: acc <= acc + (prod_reg << (i+j)*BLOCK_LENGTH), acc is 2*DATA_LENGTH bits; the sum cannot overflow the final width -> compute_chk.
- compute_chk:
  - If i==NUM_BLOCKS-1 and j==NUM_BLOCKS-1 -> finish.
  - Otherwise j wraps to 0 and i increments when j==NUM_BLOCKS-1, else j increments -> compute_mul.
  - Loop order: i (A block) outer, j (B block) inner.
- finish: result_o <= acc; done_o=1 for this cycle only -> idle unconditionally. start_i in finish is ignored.
- Latency: with start sampled in cycle 0, done_o is high in cycle 2+3*NUM_MULS (50 for the defaults). A new start is accepted in the cycle after done_o.
- busy_o is combinational from state; done_o is decoded from state==finish.

Optional Feature:
- Macro: ITER_MUL_ZERO_SKIP_EN.
- Defined: in compute_mul, if a_blk[i]==0 or b_blk[j]==0, go directly to compute_chk; acc is unchanged and prod_reg is don't-care. Each skipped pair saves 1 cycle. Latency = 2+3*P+2*(NUM_MULS-P), where P is the number of pairs with both blocks nonzero.
- Undefined: fixed latency 2+3*NUM_MULS; no zero detection logic.

Decomposition:
- Package iter_mul_pkg holds:
  - DATA_LENGTH, BLOCK_LENGTH, LENGTH;
  - NUM_BLOCKS=DATA_LENGTH/BLOCK_LENGTH and NUM_MULS=NUM_BLOCKS*NUM_BLOCKS;
  - state_t enum, counter_t (LENGTH bits), block_t, product_t (2*BLOCK_LENGTH), acc_t (2*DATA_LENGTH).
- Sub-module iter_block_mul: registered BLOCK_LENGTH x BLOCK_LENGTH unsigned multiplier with enable, used in compute_mul, for synthesis mapping to a DSP.

Test Plan:
- Reset: assert reset for 2 cycles -> busy_o=0, done_o=0, result_o=0; state idle.
- a=b=64'hFFFF_FFFF_FFFF_FFFF, start in cycle 0 -> done_o in cycle 50; result_o=128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, held after done.
- a=64'h0000_0001_0000_0002, b=64'h3 -> result_o=128'h3_0000_0006. Operands changed during busy have no effect.
- start_i held high throughout -> exactly one done per 51 cycles: start accepted in cycle 0, done in cycle 50, next start accepted in cycle 51, next done in cycle 101.
- Start a=b=all-ones, assert reset in cycle 20 -> idle with outputs zeroed next cycle. New op a=5, b=7 -> result_o=35.
- ITER_MUL_ZERO_SKIP_EN defined:
  - a=0, b=64'h1234 -> result 0, done in cycle 34.
  - a=1, b=1 -> result 1, done in cycle 35.
  - Undefined: both cases complete in cycle 50.

Source files
------------

// File: rtl/iter_mul_pkg.sv
// Shared types and sizing for the iterative block multiplier.
// Optional build macro: ITER_MUL_ZERO_SKIP_EN (skip block pairs with a zero block).
package iter_mul_pkg;

    localparam int DATA_LENGTH  = 64;
    localparam int BLOCK_LENGTH = 16;
    localparam int LENGTH       = 16;

    localparam int NUM_BLOCKS = DATA_LENGTH / BLOCK_LENGTH;
    localparam int NUM_MULS   = NUM_BLOCKS * NUM_BLOCKS;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_COMPUTE_MUL,
        ST_COMPUTE_ACC,
        ST_COMPUTE_CHK,
        ST_FINISH
    } state_t;

    typedef logic [LENGTH-1:0]         counter_t;
    typedef logic [BLOCK_LENGTH-1:0]   block_t;
    typedef logic [2*BLOCK_LENGTH-1:0] product_t;
    typedef logic [DATA_LENGTH-1:0]    operand_t;
    typedef logic [2*DATA_LENGTH-1:0]  acc_t;

    localparam counter_t LAST_IDX = counter_t'(NUM_BLOCKS - 1);

    // Block idx of an operand, block 0 being the least significant.
    function automatic block_t get_block(input operand_t op, input counter_t idx);
        return block_t'(op >> (32'(idx) * 32'(BLOCK_LENGTH)));
    endfunction

    // Block-pair product moved to its weight inside the full-width product.
    function automatic acc_t place_product(input product_t p, input counter_t i,
                                           input counter_t j);
        return acc_t'(p) << ((32'(i) + 32'(j)) * 32'(BLOCK_LENGTH));
    endfunction

endpackage

// File: rtl/iter_block_mul.sv
// Registered BLOCK_LENGTH x BLOCK_LENGTH unsigned multiplier with load enable.
// Kept as a plain registered multiply so synthesis can map it onto a DSP slice.
module iter_block_mul
    import iter_mul_pkg::*;
(
    input  logic     clk,
    input  logic     i_en,
    input  block_t   i_a,
    input  block_t   i_b,
    output product_t o_prod
);

    product_t r_prod;

    // Capture the block product whenever the controller requests a multiply.
    // NOTE: r_prod has no reset: it is always written before it is read, and a
    // reset-free register packs into the DSP's output register.
    always_ff @(posedge clk) begin
        if (i_en) begin
            r_prod <= product_t'(i_a) * product_t'(i_b);
        end
    end

    assign o_prod = r_prod;

endmodule

// File: rtl/iter_block_multiplier.sv
// Iterative schoolbook multiplier: DATA_LENGTH x DATA_LENGTH -> 2*DATA_LENGTH,
// one block-pair product per mul/acc/chk round, A block outer, B block inner.
// Optional build macro: ITER_MUL_ZERO_SKIP_EN (pairs with a zero block bypass
// the accumulate step).
module iter_block_multiplier
    import iter_mul_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     start_i,
    input  operand_t a_i,
    input  operand_t b_i,
    output logic     busy_o,
    output logic     done_o,
    output acc_t     result_o
);

    state_t   r_state;
    state_t   w_next_state;
    operand_t r_a;
    operand_t r_b;
    counter_t r_i;
    counter_t r_j;
    acc_t     r_acc;
    acc_t     r_result;

    logic     w_mul_en;
    logic     w_last_pair;
    block_t   w_a_blk;
    block_t   w_b_blk;
    product_t w_prod;

    assign w_a_blk     = get_block(r_a, r_i);
    assign w_b_blk     = get_block(r_b, r_j);
    assign w_last_pair = (r_i == LAST_IDX) && (r_j == LAST_IDX);

    iter_block_mul u_block_mul (
        .clk    (clk),
        .i_en   (w_mul_en),
        .i_a    (w_a_blk),
        .i_b    (w_b_blk),
        .o_prod (w_prod)
    );

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and multiplier enable.
    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_mul_en     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_next_state = ST_INIT;
                end
            end
            ST_INIT: begin
                w_next_state = ST_COMPUTE_MUL;
            end
            ST_COMPUTE_MUL: begin
                w_mul_en = 1'b1;
`ifdef ITER_MUL_ZERO_SKIP_EN
                // A zero block makes the pair product zero; skip accumulating it.
                if ((w_a_blk == '0) || (w_b_blk == '0)) begin
                    w_next_state = ST_COMPUTE_CHK;
                end else begin
                    w_next_state = ST_COMPUTE_ACC;
                end
`else
                w_next_state = ST_COMPUTE_ACC;
`endif
            end
            ST_COMPUTE_ACC: begin
                w_next_state = ST_COMPUTE_CHK;
            end
            ST_COMPUTE_CHK: begin
                w_next_state = w_last_pair ? ST_FINISH : ST_COMPUTE_MUL;
            end
            ST_FINISH: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Operand capture, loop counters, accumulator and result register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_i      <= '0;
            r_j      <= '0;
            r_acc    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_a <= a_i;
                        r_b <= b_i;
                    end
                end
                ST_INIT: begin
                    r_acc <= '0;
                    r_i   <= '0;
                    r_j   <= '0;
                end
                ST_COMPUTE_ACC: begin
                    r_acc <= r_acc + place_product(w_prod, r_i, r_j);
                end
                ST_COMPUTE_CHK: begin
                    if (!w_last_pair) begin
                        if (r_j == LAST_IDX) begin
                            r_j <= '0;
                            r_i <= r_i + counter_t'(1);
                        end else begin
                            r_j <= r_j + counter_t'(1);
                        end
                    end
                end
                ST_FINISH: begin
                    r_result <= r_acc;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy_o   = (r_state != ST_IDLE);
    assign done_o   = (r_state == ST_FINISH);
    assign result_o = r_result;

endmodule

// File: tb/tb_iter_block_multiplier.sv
// Self-checking bench for iter_block_multiplier: a cycle-count model of the
// handshake plus full-width arithmetic for the product, compared every cycle,
// with literal expectations for the documented operand cases.
// Honours ITER_MUL_ZERO_SKIP_EN when the same macro is given to the build.
module tb_iter_block_multiplier;
    import iter_mul_pkg::*;

    logic     clk     = 1'b0;
    logic     reset   = 1'b1;
    logic     start_i = 1'b0;
    operand_t a_i     = '0;
    operand_t b_i     = '0;
    logic     busy_o;
    logic     done_o;
    acc_t     result_o;

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    localparam operand_t ALL_ONES = {DATA_LENGTH{1'b1}};

    iter_block_multiplier dut (
        .clk      (clk),
        .reset    (reset),
        .start_i  (start_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input acc_t act, input acc_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic operand_t rand_op();
        return {$urandom, $urandom};
    endfunction

    // Cycles from the start-sampling cycle to the done cycle.
    function automatic int exp_latency(input operand_t a, input operand_t b);
        int p = 0;
        for (int i = 0; i < NUM_BLOCKS; i++) begin
            for (int j = 0; j < NUM_BLOCKS; j++) begin
                if (((a >> (i * BLOCK_LENGTH)) & {BLOCK_LENGTH{1'b1}}) != 0 &&
                    ((b >> (j * BLOCK_LENGTH)) & {BLOCK_LENGTH{1'b1}}) != 0) begin
                    p++;
                end
            end
        end
`ifdef ITER_MUL_ZERO_SKIP_EN
        return 2 + 3 * p + 2 * (NUM_MULS - p);
`else
        return 2 + 3 * NUM_MULS + 0 * p;
`endif
    endfunction

    // Behavioural model: busy window, done cycle and product, counted in cycles.
    logic m_busy = 1'b0;
    logic m_done = 1'b0;
    int   m_left = 0;
    acc_t m_res  = '0;
    acc_t m_prod = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_left <= 0;
            m_res  <= '0;
        end else if (m_done) begin
            m_res  <= m_prod;
            m_done <= 1'b0;
            m_busy <= 1'b0;
        end else if (m_busy) begin
            m_left <= m_left - 1;
            if (m_left == 1) m_done <= 1'b1;
        end else if (start_i) begin
            m_busy <= 1'b1;
            m_prod <= acc_t'(a_i) * acc_t'(b_i);
            m_left <= exp_latency(a_i, b_i) - 1;
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy_o", acc_t'(busy_o), acc_t'(m_busy));
            check("done_o", acc_t'(done_o), acc_t'(m_done));
            check("result_o", result_o, m_res);
        end
    end

    // One operation: start in cycle 0, scramble operands while busy, measure
    // the done cycle, return at the first cycle after finish.
    task automatic run_op(input operand_t a, input operand_t b, input int lat,
                          input string tag);
        int n;
        @(negedge clk);
        start_i = 1'b1;
        a_i     = a;
        b_i     = b;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        a_i     = rand_op();
        b_i     = rand_op();
        n = 1;
        @(negedge clk);
        while (!done_o && n < 300) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check({tag, " done cycle"}, acc_t'(n), acc_t'(lat));
        @(negedge clk);
    endtask

    initial begin
        int n;
        operand_t ra, rb;

        // Reset held for two cycles.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("reset busy", acc_t'(busy_o), '0);
        check("reset done", acc_t'(done_o), '0);
        check("reset result", result_o, '0);
        reset = 1'b0;

        // All-ones operands: every pair nonzero, full latency either build.
        run_op(ALL_ONES, ALL_ONES, 50, "all_ones");
        check("all_ones result", result_o, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
        repeat (3) @(negedge clk);
        check("all_ones held", result_o, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);

        run_op(64'h0000_0001_0000_0002, 64'h3,
               exp_latency(64'h0000_0001_0000_0002, 64'h3), "small");
        check("small result", result_o, 128'h3_0000_0006);

        // start_i held high: one done per 51 cycles.
        @(negedge clk);
        start_i = 1'b1;
        a_i     = ALL_ONES;
        b_i     = ALL_ONES;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!done_o && n < 300);
        check("held first done", acc_t'(n), acc_t'(50));
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!done_o && n < 400);
        check("held second done", acc_t'(n), acc_t'(101));
        start_i = 1'b0;
        @(negedge clk);
        check("held result", result_o, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
        check("held idle", acc_t'(busy_o), '0);

        // Reset in cycle 20 of an operation.
        @(negedge clk);
        start_i = 1'b1;
        a_i     = ALL_ONES;
        b_i     = ALL_ONES;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midreset busy", acc_t'(busy_o), '0);
        check("midreset done", acc_t'(done_o), '0);
        check("midreset result", result_o, '0);
        reset = 1'b0;
`ifdef ITER_MUL_ZERO_SKIP_EN
        run_op(64'd5, 64'd7, 35, "five_seven");
`else
        run_op(64'd5, 64'd7, 50, "five_seven");
`endif
        check("five_seven result", result_o, 128'd35);

        // Zero-block cases: shortened only when skipping is built in.
`ifdef ITER_MUL_ZERO_SKIP_EN
        run_op(64'd0, 64'h1234, 34, "zero_a");
`else
        run_op(64'd0, 64'h1234, 50, "zero_a");
`endif
        check("zero_a result", result_o, 128'd0);
`ifdef ITER_MUL_ZERO_SKIP_EN
        run_op(64'd1, 64'd1, 35, "one_one");
`else
        run_op(64'd1, 64'd1, 50, "one_one");
`endif
        check("one_one result", result_o, 128'd1);

        // Random operands with randomly zeroed blocks.
        for (int k = 0; k < 12; k++) begin
            ra = rand_op();
            rb = rand_op();
            for (int blk = 0; blk < NUM_BLOCKS; blk++) begin
                if ($urandom_range(0, 1) == 0) ra[blk*BLOCK_LENGTH +: BLOCK_LENGTH] = '0;
                if ($urandom_range(0, 2) == 0) rb[blk*BLOCK_LENGTH +: BLOCK_LENGTH] = '0;
            end
            run_op(ra, rb, exp_latency(ra, rb), "random");
            check("random result", result_o, acc_t'(ra) * acc_t'(rb));
        end

        repeat (2) @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
